tt_um_hoene_protocol_transmitter: RTL and testbench
===================================================

TT_UM_HOENE_PROTOCOL_TRANSMITTER -- requirements
Module: tt_um_hoene_protocol_transmitter

Interface
REQ-001 Parameter HALF_BIT, default 8: clocks per Manchester half-bit; legal range 2..63.
REQ-002 Parameter PREAMBLE_BITS, default 8: number of '1' bits in the preamble; legal range 1..15.
REQ-003 Parameter GAP_BITS, default 2: idle bit periods after each frame; legal range 0..7.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_red  input  10  red value to transmit.
REQ-008 in_green  input  10  green value to transmit.
REQ-009 in_blue  input  10  blue value to transmit.
REQ-010 in_valid  input  1  the in_* triple is valid.
REQ-011 in_ready  output  1  the block accepts a triple this cycle.
REQ-012 out  output  1  Manchester line, registered.
REQ-013 out_bit_strobe  output  1  one-cycle pulse in the first clock of every transmitted bit.
REQ-014 out_busy  output  1  a frame or its trailing gap is in progress.

Function
REQ-015 Handshake: the triple SHALL be captured into internal registers in the cycle where in_valid=1 and in_ready=1; the in_* inputs are ignored at all other times.
REQ-016 in_ready SHALL be 1 only in IDLE; it is combinational from state and never depends on in_valid.
REQ-017 States: IDLE -> PREAMBLE -> START -> DATA -> PARITY -> GAP -> IDLE; GAP is skipped when GAP_BITS=0.
REQ-018 Frame bit order: PREAMBLE_BITS x '1'; start bit '0'; 30 data bits in the order red[9..0], green[9..0], blue[9..0]; one parity bit.
REQ-019 The parity bit SHALL equal the XOR of the 30 data bits (even parity).
REQ-020 Encoding: bit '1' = out high for HALF_BIT clocks then low for HALF_BIT clocks; bit '0' = low then high.
REQ-021 Each bit SHALL last exactly 2*HALF_BIT clocks, with no gaps or stretch between consecutive bits.
REQ-022 Latency: the first preamble half-bit SHALL appear on out in the cycle after the capture cycle.
REQ-023 out_busy SHALL rise in that same cycle.
REQ-024 During GAP and IDLE, out SHALL be 0.
REQ-025 GAP SHALL last GAP_BITS*2*HALF_BIT clocks.
REQ-026 out_bit_strobe SHALL pulse in the first cycle of every preamble, start, data and parity bit, and never during GAP.
REQ-027 With default parameters, a frame occupies 40 bits = 640 clocks plus a 32-clock gap.
REQ-028 in_ready SHALL return to 1 exactly 672 clocks after the first frame cycle.
REQ-029 Back-to-back frames: when in_valid is held high, the next capture SHALL occur in the first IDLE cycle, and its frame SHALL start on the following cycle.
REQ-030 Input changes while busy SHALL NOT affect the frame in progress.
REQ-031 Counters: the half-bit counter is 6 bits wide and the bit index is 6 bits wide; both wrap only under state control, never by overflow.

Reset
REQ-032 While rst=1, the block SHALL hold: state IDLE, out=0, out_bit_strobe=0, out_busy=0, in_ready=0.
REQ-033 While rst=1, all counters and the captured data SHALL be cleared.
REQ-034 Assertion of rst mid-frame SHALL force out=0 and clear out_busy immediately (asynchronously); the partial frame is abandoned.
REQ-035 In the first clock edge after rst deasserts, the block SHALL be in IDLE with in_ready=1.

Verification
REQ-036 Reset: assert rst mid-frame -> out=0 and out_busy=0 without waiting for a clock edge; after release, in_ready=1.
REQ-037 Single frame, defaults, red=0x3FF, green=0x000, blue=0x155 -> sample out at each bit's midpoint-1 and midpoint+1.
REQ-038 The decoded bits for REQ-037 SHALL be 8x'1', '0', 1111111111, 0000000000, 0101010101, parity '1'; out_bit_strobe count = 40.
REQ-039 Timing, defaults -> every out edge lands on a multiple of 8 clocks from frame start; in_ready rises at clock 672.
REQ-040 Back-to-back, in_valid held, two triples (0x001,0x002,0x003) then (0x3FF,0x3FF,0x3FF) -> second frame starts 673 clocks after the first; second parity bit '0'.
REQ-041 Handshake, defaults: toggle in_valid and change in_* during a frame -> the frame is unchanged and no capture occurs until in_ready=1.
REQ-042 Minimum config: HALF_BIT=2, PREAMBLE_BITS=1, GAP_BITS=0 -> the frame is 33 bits = 132 clocks; in_ready returns at clock 132; the bits decode correctly.

Source files
------------

// File: rtl/tt_um_hoene_protocol_transmitter.sv
// Manchester-encoded RGB frame transmitter: preamble of ones, start bit, 30 data bits, even parity, idle gap.
// One 30-bit RGB triple is accepted per frame through a valid/ready handshake.
module tt_um_hoene_protocol_transmitter #(
    parameter int HALF_BIT      = 8,
    parameter int PREAMBLE_BITS = 8,
    parameter int GAP_BITS      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_red,
    input  logic [9:0] in_green,
    input  logic [9:0] in_blue,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out,
    output logic       out_bit_strobe,
    output logic       out_busy
);

    if (HALF_BIT < 2 || HALF_BIT > 63) begin : g_bad_half_bit
        $error("HALF_BIT out of range 2..63");
    end
    if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 15) begin : g_bad_preamble
        $error("PREAMBLE_BITS out of range 1..15");
    end
    if (GAP_BITS < 0 || GAP_BITS > 7) begin : g_bad_gap
        $error("GAP_BITS out of range 0..7");
    end

    localparam logic [5:0] HALF_LAST = 6'(HALF_BIT - 1);
    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_BITS - 1);
    localparam logic [5:0] GAP_LAST  = 6'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [5:0] DATA_LAST = 6'd29;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        PARITY,
        GAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  half_cnt;
    logic [5:0]  half_cnt_nx;
    logic [5:0]  bit_idx;
    logic [5:0]  bit_idx_nx;
    logic        phase;
    logic        phase_nx;
    logic [29:0] data_q;
    logic        parity_q;
    logic        accept;
    logic        bit_end;
    logic        bit_val;
    logic        line_nx;
    logic        strobe_nx;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign out_busy = (state != IDLE);
    assign bit_end  = (half_cnt == HALF_LAST) && phase;

    // phase=0 is the first half of a bit; a bit ends after the second half's last clock
    always_comb begin
        state_nx    = state;
        half_cnt_nx = half_cnt;
        phase_nx    = phase;
        bit_idx_nx  = bit_idx;
        if (state == IDLE) begin
            half_cnt_nx = 6'd0;
            phase_nx    = 1'b0;
            bit_idx_nx  = 6'd0;
            if (accept) begin
                state_nx = PREAMBLE;
            end
        end else begin
            if (half_cnt == HALF_LAST) begin
                half_cnt_nx = 6'd0;
                phase_nx    = ~phase;
            end else begin
                half_cnt_nx = half_cnt + 6'd1;
            end
            if (bit_end) begin
                bit_idx_nx = bit_idx + 6'd1;
                unique case (state)
                    PREAMBLE: begin
                        if (bit_idx == PRE_LAST) begin
                            state_nx   = START;
                            bit_idx_nx = 6'd0;
                        end
                    end
                    START: begin
                        state_nx   = DATA;
                        bit_idx_nx = 6'd0;
                    end
                    DATA: begin
                        if (bit_idx == DATA_LAST) begin
                            state_nx   = PARITY;
                            bit_idx_nx = 6'd0;
                        end
                    end
                    PARITY: begin
                        bit_idx_nx = 6'd0;
                        state_nx   = (GAP_BITS == 0) ? IDLE : GAP;
                    end
                    GAP: begin
                        if (bit_idx == GAP_LAST) begin
                            state_nx   = IDLE;
                            bit_idx_nx = 6'd0;
                        end
                    end
                    default: begin
                        state_nx   = IDLE;
                        bit_idx_nx = 6'd0;
                    end
                endcase
            end
        end
    end

    // The line is computed from next-state values so that out itself is a plain register
    always_comb begin
        bit_val   = 1'b0;
        line_nx   = 1'b0;
        strobe_nx = 1'b0;
        unique case (state_nx)
            PREAMBLE: bit_val = 1'b1;
            START:    bit_val = 1'b0;
            DATA: begin
                for (int i = 0; i < 30; i++) begin
                    if (bit_idx_nx == 6'(i)) begin
                        bit_val = data_q[29 - i];
                    end
                end
            end
            PARITY:   bit_val = parity_q;
            default:  bit_val = 1'b0;
        endcase
        if (state_nx inside {PREAMBLE, START, DATA, PARITY}) begin
            line_nx   = bit_val ^ phase_nx;
            strobe_nx = (half_cnt_nx == 6'd0) && !phase_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            half_cnt       <= 6'd0;
            phase          <= 1'b0;
            bit_idx        <= 6'd0;
            data_q         <= 30'd0;
            parity_q       <= 1'b0;
            out            <= 1'b0;
            out_bit_strobe <= 1'b0;
        end else begin
            state          <= state_nx;
            half_cnt       <= half_cnt_nx;
            phase          <= phase_nx;
            bit_idx        <= bit_idx_nx;
            out            <= line_nx;
            out_bit_strobe <= strobe_nx;
            if (accept) begin
                data_q   <= {in_red, in_green, in_blue};
                parity_q <= ^{in_red, in_green, in_blue};
            end
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_protocol_transmitter.sv
// Scoreboard bench: stimulus pushes hand-specified frame bits, a per-cycle monitor decodes the Manchester line.
// Instance a uses default parameters, instance b the minimum configuration.
module tb_tt_um_hoene_protocol_transmitter;

    localparam int HB_A   = 8;
    localparam int PB_A   = 8;
    localparam int BITS_A = 40;
    localparam int LEN_A  = 672;
    localparam int HB_B   = 2;
    localparam int PB_B   = 1;
    localparam int BITS_B = 33;
    localparam int LEN_B  = 132;

    logic       clk;
    logic       rst;
    logic [9:0] a_red, a_green, a_blue;
    logic       a_valid, a_ready, a_out, a_strobe, a_busy;
    logic [9:0] b_red, b_green, b_blue;
    logic       b_valid, b_ready, b_out, b_strobe, b_busy;

    int checks   = 0;
    int failures = 0;
    bit exp_a[$];
    bit exp_b[$];

    int   frame_cyc[2];
    int   cyc_in_bit[2];
    int   strobe_cnt[2];
    logic prev_out[2];
    logic prev_busy[2];
    logic in_bit[2];
    logic s1[2];

    tt_um_hoene_protocol_transmitter dut_a (
        .clk(clk), .rst(rst),
        .in_red(a_red), .in_green(a_green), .in_blue(a_blue),
        .in_valid(a_valid), .in_ready(a_ready),
        .out(a_out), .out_bit_strobe(a_strobe), .out_busy(a_busy)
    );

    tt_um_hoene_protocol_transmitter #(
        .HALF_BIT(2), .PREAMBLE_BITS(1), .GAP_BITS(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_red(b_red), .in_green(b_green), .in_blue(b_blue),
        .in_valid(b_valid), .in_ready(b_ready),
        .out(b_out), .out_bit_strobe(b_strobe), .out_busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpected(input int id, input int pb, input logic [9:0] r, input logic [9:0] g,
                                input logic [9:0] bl, input bit par);
        logic [29:0] d;
        bit v;
        d = {r, g, bl};
        for (int i = 0; i < pb + 32; i++) begin
            if (i < pb) v = 1'b1;
            else if (i == pb) v = 1'b0;
            else if (i < pb + 31) v = d[29 - (i - pb - 1)];
            else v = par;
            if (id == 0) exp_a.push_back(v);
            else exp_b.push_back(v);
        end
    endtask

    task automatic monitorStep(input int id, input int half, input int bits, input int len,
                               input logic o, input logic st, input logic busy, input logic rdy, input logic r);
        logic s2;
        bit exp_bit;
        bit have;
        if (r) begin
            frame_cyc[id]  = 0;
            cyc_in_bit[id] = 0;
            strobe_cnt[id] = 0;
            prev_out[id]   = 1'b0;
            prev_busy[id]  = 1'b0;
            in_bit[id]     = 1'b0;
            return;
        end
        if (busy && !prev_busy[id]) begin
            frame_cyc[id]  = 0;
            strobe_cnt[id] = 0;
        end else begin
            frame_cyc[id]++;
        end
        if (o !== prev_out[id]) checkOutput("edge_align", frame_cyc[id] % half, 0);
        if (!busy) checkOutput("idle_out_low", o, 0);
        if (!busy && prev_busy[id]) begin
            checkOutput("frame_len", frame_cyc[id], len);
            checkOutput("ready_return", rdy, 1);
            checkOutput("strobe_count", strobe_cnt[id], bits);
        end
        if (st) begin
            strobe_cnt[id]++;
            checkOutput("strobe_align", frame_cyc[id] % (2 * half), 0);
            checkOutput("strobe_in_frame", (busy && frame_cyc[id] < bits * 2 * half), 1);
            cyc_in_bit[id] = 0;
            in_bit[id]     = 1'b1;
        end else begin
            cyc_in_bit[id]++;
        end
        if (in_bit[id] && cyc_in_bit[id] == half - 1) s1[id] = o;
        if (in_bit[id] && cyc_in_bit[id] == half + 1) begin
            s2 = o;
            in_bit[id] = 1'b0;
            checkOutput("manchester_valid", s1[id] ^ s2, 1);
            have = (id == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
            if (!have) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_bit dut=%0d actual=%0b required=none", id, s1[id]);
            end else begin
                if (id == 0) exp_bit = exp_a.pop_front();
                else exp_bit = exp_b.pop_front();
                checkOutput("bit_value", s1[id], exp_bit);
            end
        end
        prev_out[id]  = o;
        prev_busy[id] = busy;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            monitorStep(0, HB_A, BITS_A, LEN_A, a_out, a_strobe, a_busy, a_ready, rst);
            monitorStep(1, HB_B, BITS_B, LEN_B, b_out, b_strobe, b_busy, b_ready, rst);
        end
    end

    // Called and returns at a negedge; cap_time is the index of the capturing clock edge
    task automatic applyStimulus(input int id, input logic [9:0] r, input logic [9:0] g, input logic [9:0] bl,
                                 input bit par, input bit hold, output int cap_time);
        bit rdy;
        bit done;
        done     = 1'b0;
        cap_time = 0;
        if (id == 0) begin
            a_red = r; a_green = g; a_blue = bl; a_valid = 1'b1;
        end else begin
            b_red = r; b_green = g; b_blue = bl; b_valid = 1'b1;
        end
        for (int n = 0; n < 2000 && !done; n++) begin
            rdy = (id == 0) ? a_ready : b_ready;
            if (rdy) begin
                pushExpected(id, (id == 0) ? PB_A : PB_B, r, g, bl, par);
                @(posedge clk);
                cap_time = int'($time / 10);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout dut=%0d actual=no_capture required=capture", id);
        end
        if (!hold || !done) begin
            if (id == 0) a_valid = 1'b0;
            else b_valid = 1'b0;
        end
    endtask

    task automatic waitIdle(input int id, input int bound);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < bound && !idle; n++) begin
            idle = (id == 0) ? !a_busy : !b_busy;
            if (!idle) @(negedge clk);
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout dut=%0d actual=busy required=idle", id);
        end
    endtask

    initial begin
        int t1;
        int t2;
        bit seen_high;
        rst = 1'b1;
        a_red = '0; a_green = '0; a_blue = '0; a_valid = 1'b0;
        b_red = '0; b_green = '0; b_blue = '0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out", a_out, 0);
        checkOutput("rst_strobe", a_strobe, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_ready", a_ready, 0);
        checkOutput("rst_ready_b", b_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", a_ready, 1);
        checkOutput("post_rst_ready_b", b_ready, 1);

        $display("[TB] single frame, defaults");
        applyStimulus(0, 10'h3FF, 10'h000, 10'h155, 1'b1, 1'b0, t1);
        checkOutput("busy_after_capture", a_busy, 1);
        waitIdle(0, 800);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained_single", exp_a.size(), 0);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 10'h001, 10'h002, 10'h003, 1'b0, 1'b1, t1);
        applyStimulus(0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b0, t2);
        checkOutput("b2b_interval", t2 - t1, 673);
        waitIdle(0, 800);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained_b2b", exp_a.size(), 0);

        $display("[TB] input changes while busy");
        applyStimulus(0, 10'h0AA, 10'h155, 10'h001, 1'b0, 1'b0, t1);
        for (int n = 0; n < 200; n++) begin
            a_valid = 1'($urandom_range(0, 1));
            a_red   = 10'($urandom);
            a_green = 10'($urandom);
            a_blue  = 10'($urandom);
            @(negedge clk);
        end
        a_valid = 1'b0;
        waitIdle(0, 800);
        repeat (5) @(negedge clk);
        checkOutput("no_spurious_capture", a_busy, 0);
        checkOutput("queue_drained_handshake", exp_a.size(), 0);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(0, 10'h3FF, 10'h000, 10'h155, 1'b1, 1'b0, t1);
        repeat (40) @(negedge clk);
        seen_high = 1'b0;
        for (int n = 0; n < 40 && !seen_high; n++) begin
            seen_high = a_out;
            if (!seen_high) @(negedge clk);
        end
        checkOutput("pre_reset_out_high", a_out, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_out", a_out, 0);
        checkOutput("async_busy", a_busy, 0);
        checkOutput("async_ready", a_ready, 0);
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", a_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("idle_after_rst_ready", a_ready, 1);
        checkOutput("idle_after_rst_busy", a_busy, 0);
        @(negedge clk);

        $display("[TB] minimum configuration");
        applyStimulus(1, 10'h2A5, 10'h0F0, 10'h3C0, 1'b1, 1'b0, t1);
        waitIdle(1, 300);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained_min", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
